execute_arbiter: RTL and testbench

Round-robin arbiter that time-shares one `Execute` stage (ALU plus SrcB mux) among `NREQ` requesters, such as the scalar pipeline and auxiliary units. It accepts at most one operation per cycle through a valid/ready handshake and registers the operands into an issue slot that drives `Execute`. It then registers the ALU result and flags into a tagged response slot that is broadcast back to the requesters. Throughput is one operation per cycle; the response returns 2 cycles after acceptance.

---
 rtl/execute_arb_pkg.sv | 14 +
 rtl/rr_picker.sv | 33 +++
 rtl/execute_arbiter.sv | 109 ++++++++++
 tb/tb_execute_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_arb_pkg.sv
// Shared types, ALU control encodings and sizing helper for the execute arbiter.
package execute_arb_pkg;

  typedef logic [3:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_NOP = 4'b0000;
  localparam alu_ctrl_t ALU_ADD = 4'b0010;

  // Requester-id width, never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Circular priority picker: first set request strictly after the pointer, wrapping around.
module rr_picker
  import execute_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]       req,
  input  logic [id_w(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]       grant_c,
  output logic [id_w(NREQ)-1:0] idx_c
);

  localparam int unsigned IDW = id_w(NREQ);

  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found         = 1'b1;
        grant_c[cand] = 1'b1;
        idx_c         = cand;
      end
    end
  end

endmodule

// File: rtl/execute_arbiter.sv
// Round-robin sharing of one Execute stage: grant, issue slot, tagged response slot.
module execute_arbiter
  import execute_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_alusrc,
  input  logic [4*NREQ-1:0]       req_ctrl,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  input  logic [WIDTH*NREQ-1:0]   req_imm,
  input  logic                    stall,
  output logic                    ALUSrcE,
  output logic [3:0]              ALUControlE,
  output logic [WIDTH-1:0]        SrcAE,
  output logic [WIDTH-1:0]        WriteDataE,
  output logic [WIDTH-1:0]        ExtImmE,
  input  logic [WIDTH-1:0]        ALUResultE,
  input  logic [3:0]              ALUFlags,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_result,
  output logic [3:0]              rsp_flags,
  output logic                    busy
);

  localparam int unsigned IDW = id_w(NREQ);

  logic [IDW-1:0]   last_grant;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gidx;
  logic             hs;
  logic             iss_valid;
  logic [IDW-1:0]   iss_id;
  logic             sel_alusrc;
  alu_ctrl_t        sel_ctrl;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] sel_imm;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req     (req_valid),
    .ptr     (last_grant),
    .grant_c (grant),
    .idx_c   (gidx)
  );

  assign req_ready = (reset || stall) ? '0 : grant;
  assign hs        = |req_ready;

  // Operand mux for the granted requester.
  always_comb begin
    sel_alusrc = 1'b0;
    sel_ctrl   = ALU_NOP;
    sel_a      = '0;
    sel_b      = '0;
    sel_imm    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gidx == IDW'(i)) begin
        sel_alusrc = req_alusrc[i];
        sel_ctrl   = req_ctrl[4*i +: 4];
        sel_a      = req_a[WIDTH*i +: WIDTH];
        sel_b      = req_b[WIDTH*i +: WIDTH];
        sel_imm    = req_imm[WIDTH*i +: WIDTH];
      end
    end
  end

  // Operands are cleared when the slot is empty so Execute sees ALU_NOP and zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant  <= IDW'(NREQ - 1);
      iss_valid   <= 1'b0;
      iss_id      <= '0;
      ALUSrcE     <= 1'b0;
      ALUControlE <= ALU_NOP;
      SrcAE       <= '0;
      WriteDataE  <= '0;
      ExtImmE     <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      busy        <= 1'b0;
    end else begin
      if (hs) last_grant <= gidx;
      iss_valid   <= hs;
      iss_id      <= hs ? gidx : '0;
      ALUSrcE     <= hs & sel_alusrc;
      ALUControlE <= hs ? sel_ctrl : ALU_NOP;
      SrcAE       <= hs ? sel_a : '0;
      WriteDataE  <= hs ? sel_b : '0;
      ExtImmE     <= hs ? sel_imm : '0;
      rsp_valid   <= iss_valid;
      rsp_id      <= iss_id;
      if (iss_valid) begin
        rsp_result <= ALUResultE;
        rsp_flags  <= ALUFlags;
      end
      busy        <= hs | iss_valid;
    end
  end

endmodule

// File: tb/tb_execute_arbiter.sv
// Directed bench for execute_arbiter with a small adder model standing in for Execute.
module tb_execute_arbiter;
  import execute_arb_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NREQ  = 4;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_alusrc;
  logic [4*NREQ-1:0]     req_ctrl;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [WIDTH*NREQ-1:0] req_imm;
  logic                  stall;
  logic                  ALUSrcE;
  logic [3:0]            ALUControlE;
  logic [WIDTH-1:0]      SrcAE;
  logic [WIDTH-1:0]      WriteDataE;
  logic [WIDTH-1:0]      ExtImmE;
  logic [WIDTH-1:0]      ALUResultE;
  logic [3:0]            ALUFlags;
  logic                  rsp_valid;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic [3:0]            rsp_flags;
  logic                  busy;

  int n_checks;
  int n_fail;

  execute_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_alusrc(req_alusrc),
    .req_ctrl(req_ctrl), .req_a(req_a), .req_b(req_b), .req_imm(req_imm),
    .stall(stall),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .SrcAE(SrcAE),
    .WriteDataE(WriteDataE), .ExtImmE(ExtImmE),
    .ALUResultE(ALUResultE), .ALUFlags(ALUFlags),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Execute stand-in: add only, flags {N,Z,C,V}.
  logic [WIDTH-1:0] srcb;
  logic [WIDTH:0]   ext;
  always_comb begin
    srcb = ALUSrcE ? ExtImmE : WriteDataE;
    ext  = {1'b0, SrcAE} + {1'b0, srcb};
    if (ALUControlE == ALU_ADD) begin
      ALUResultE = ext[WIDTH-1:0];
      ALUFlags   = {ext[WIDTH-1], ext[WIDTH-1:0] == '0, ext[WIDTH],
                    (SrcAE[WIDTH-1] == srcb[WIDTH-1]) && (ext[WIDTH-1] != SrcAE[WIDTH-1])};
    end else begin
      ALUResultE = '0;
      ALUFlags   = '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic alusrc, input alu_ctrl_t ctrl,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] imm);
    req_alusrc[i]        = alusrc;
    req_ctrl[4*i +: 4]   = ctrl;
    req_a[8*i +: 8]      = a;
    req_b[8*i +: 8]      = b;
    req_imm[8*i +: 8]    = imm;
  endtask

  logic [3:0] exp_rdy_c [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] exp_id_c  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] exp_res_c [5] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h01};
  logic [3:0] exp_rdy_r [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
  logic [1:0] exp_id_r  [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
  logic [7:0] exp_res_r [4] = '{8'h00, 8'h80, 8'h00, 8'h80};
  logic [3:0] exp_flg_r [4] = '{4'b0110, 4'b1001, 4'b0110, 4'b1001};

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    stall      = 1'b0;
    req_valid  = 4'hF;
    req_alusrc = '0;
    req_ctrl   = '0;
    req_a      = '0;
    req_b      = '0;
    req_imm    = '0;
    step();
    step();
    chk("reset_ready", req_ready, 4'b0000);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ctrl", ALUControlE, ALU_NOP);
    chk("reset_srca", SrcAE, 8'h00);
    chk("reset_result", rsp_result, 8'h00);
    reset     = 1'b0;
    req_valid = 4'b0000;
    step();

    // Single op from requester 0.
    set_op(0, 1'b0, ALU_ADD, 8'h05, 8'h03, 8'h00);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", req_ready, 4'b0001);
    step();
    req_valid = 4'b0000;
    chk("single_srca", SrcAE, 8'h05);
    chk("single_wd", WriteDataE, 8'h03);
    chk("single_ctrl", ALUControlE, ALU_ADD);
    chk("single_rsp_early", rsp_valid, 1'b0);
    chk("single_busy", busy, 1'b1);
    step();
    chk("single_rsp_valid", rsp_valid, 1'b1);
    chk("single_rsp_id", rsp_id, 2'd0);
    chk("single_result", rsp_result, 8'h08);
    chk("single_flags", rsp_flags, 4'b0000);
    chk("single_nop", ALUControlE, ALU_NOP);
    step();
    chk("single_pulse", rsp_valid, 1'b0);
    chk("single_hold", rsp_result, 8'h08);
    chk("single_idle", busy, 1'b0);

    // Immediate select on requester 2.
    set_op(2, 1'b1, ALU_ADD, 8'h10, 8'hFF, 8'h01);
    req_valid = 4'b0100;
    #1;
    chk("imm_ready", req_ready, 4'b0100);
    step();
    req_valid = 4'b0000;
    chk("imm_alusrc", ALUSrcE, 1'b1);
    chk("imm_wd", WriteDataE, 8'hFF);
    chk("imm_ext", ExtImmE, 8'h01);
    step();
    chk("imm_rsp_valid", rsp_valid, 1'b1);
    chk("imm_rsp_id", rsp_id, 2'd2);
    chk("imm_result", rsp_result, 8'h11);

    // Contention from reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 1'b0, ALU_ADD, 8'(i * 16), 8'h01, 8'h00);
    req_valid = 4'hF;
    #1;
    for (int s = 0; s < 7; s++) begin
      if (s == 5) req_valid = 4'b0000;
      if (s < 5) chk($sformatf("cont_ready_%0d", s), req_ready, exp_rdy_c[s]);
      if (s >= 2) begin
        chk($sformatf("cont_rsp_valid_%0d", s), rsp_valid, 1'b1);
        chk($sformatf("cont_rsp_id_%0d", s), rsp_id, exp_id_c[s-2]);
        chk($sformatf("cont_result_%0d", s), rsp_result, exp_res_c[s-2]);
      end
      step();
    end
    chk("cont_drain", rsp_valid, 1'b0);

    // Rotation between requesters 1 and 3, with flag-producing operands.
    set_op(1, 1'b0, ALU_ADD, 8'hFF, 8'h01, 8'h00);
    set_op(3, 1'b0, ALU_ADD, 8'h7F, 8'h01, 8'h00);
    req_valid = 4'b1010;
    #1;
    for (int s = 0; s < 6; s++) begin
      if (s == 4) req_valid = 4'b0000;
      if (s < 4) chk($sformatf("rot_ready_%0d", s), req_ready, exp_rdy_r[s]);
      if (s >= 2) begin
        chk($sformatf("rot_rsp_id_%0d", s), rsp_id, exp_id_r[s-2]);
        chk($sformatf("rot_result_%0d", s), rsp_result, exp_res_r[s-2]);
        chk($sformatf("rot_flags_%0d", s), rsp_flags, exp_flg_r[s-2]);
      end
      step();
    end

    // Stall after an accepted op; pointer resumes after requester 0.
    set_op(0, 1'b0, ALU_ADD, 8'h22, 8'h11, 8'h00);
    req_valid = 4'b0001;
    #1;
    chk("stall_pre_ready", req_ready, 4'b0001);
    step();
    stall     = 1'b1;
    req_valid = 4'b0111;
    #1;
    chk("stall_ready0", req_ready, 4'b0000);
    chk("stall_inflight", SrcAE, 8'h22);
    step();
    chk("stall_rsp_valid", rsp_valid, 1'b1);
    chk("stall_rsp_id", rsp_id, 2'd0);
    chk("stall_result", rsp_result, 8'h33);
    chk("stall_ready1", req_ready, 4'b0000);
    chk("stall_no_issue", ALUControlE, ALU_NOP);
    step();
    chk("stall_quiet", rsp_valid, 1'b0);
    stall = 1'b0;
    #1;
    chk("stall_resume", req_ready, 4'b0010);
    step();
    req_valid = 4'b0000;
    chk("stall_resume_srca", SrcAE, 8'hFF);
    step();
    chk("stall_resume_id", rsp_id, 2'd1);
    step();

    // Reset one cycle after a handshake discards the op.
    req_valid = 4'b1000;
    #1;
    chk("rst_mid_ready", req_ready, 4'b1000);
    step();
    reset = 1'b1;
    #1;
    chk("rst_mid_ready_off", req_ready, 4'b0000);
    step();
    chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_ctrl", ALUControlE, ALU_NOP);
    chk("rst_mid_srca", SrcAE, 8'h00);
    chk("rst_mid_wd", WriteDataE, 8'h00);
    chk("rst_mid_result", rsp_result, 8'h00);
    chk("rst_mid_flags", rsp_flags, 4'b0000);
    chk("rst_mid_id", rsp_id, 2'd0);
    step();
    chk("rst_mid_no_rsp", rsp_valid, 1'b0);
    reset     = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("rst_first_grant", req_ready, 4'b0001);
    step();
    req_valid = 4'b0000;
    step();
    chk("rst_first_rsp_valid", rsp_valid, 1'b1);
    chk("rst_first_rsp_id", rsp_id, 2'd0);
    chk("rst_first_result", rsp_result, 8'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
